coin_intake: RTL and testbench
==============================

# coin_intake

Front-end conditioner for the coin slot, sitting directly upstream of the vending FSM. Synchronizes and debounces the raw `insert` button and `coin_val` switches from the board and decodes each accepted press into a coin amount. Buffers up to `FIFO_DEPTH` coins so that none are lost while the slow FSM is busy. Coins are presented to the FSM through a valid/ack handshake.

## Interface
- `DEBOUNCE_CYCLES`, 1000000: cycles a synchronized level must stay stable before it is accepted (10 ms at 100 MHz).
- `FIFO_DEPTH`, 4: coin buffer entries; power of two, 2..16.
- `clk`  in  1  system clock, 100 MHz board clock (`clk100MHZ` at top level).
- `rst_n`  in  1  asynchronous, active-low reset.
- `power`  in  1  machine power switch; low = intake disabled and flushed.
- `insert`  in  1  raw, bouncy coin-insert button.
- `coin_val`  in  2  raw coin-denomination switches.
- `coin_valid`  out  1  head-of-buffer coin available.
- `coin_amount`  out  4  value of head coin; 0 when `coin_valid` low.
- `coin_ack`  in  1  consumer accepts head coin.
- `reject_ind`  out  1  sticky: last press was rejected.
- `pending`  out  5  coins currently buffered (0..FIFO_DEPTH).

## Operation
- Reset: all flops cleared, including sync and debounce stages. `coin_valid`=0, `coin_amount`=0, `reject_ind`=0, `pending`=0.
- Sync: `insert` and both `coin_val` bits each pass through a 2-flop synchronizer.
- Debounce on synchronized `insert`:
  - When the synchronized level differs from the debounced level, a counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` with the level still differing, the debounced level flips and the counter clears.
  - Any return to equality clears the counter.
  - `coin_val` is not debounced. Its synchronized value is captured on the edge where debounced `insert` rises.
- Decode of captured code: 2'b00 → 1, 2'b01 → 5, 2'b10 → 10, 2'b11 → invalid.
- Push on debounced `insert` rising edge (one push per press; release does nothing):
  - Invalid code: no push; `reject_ind` set.
  - Buffer full with no pop in the same cycle: no push; `reject_ind` set.
  - Otherwise: push the amount; `reject_ind` cleared.
- Pop occurs when `coin_valid && coin_ack`. `coin_ack` while `coin_valid`=0 is ignored.
- Full buffer with simultaneous pop and push: both occur, and `pending` is unchanged.
- `pending` = pushes − pops. It never exceeds `FIFO_DEPTH` and never wraps. Read/write pointers wrap modulo `FIFO_DEPTH`.
- `power`=0, sampled synchronously:
  - Buffer flushed, `pending`=0, `coin_valid`=0, `reject_ind`=0.
  - Debounce counter cleared and debounced level forced to the synchronized level, so a press held across power-up does not register.
  - Pushes are blocked.
- Reset asserted mid-operation clears everything immediately. Buffered coins are lost.

## Timing
- Output is registered FIFO head: `coin_valid` and `coin_amount` change only on `clk` edges.
- Latency, with the macro defined: bounce-free `insert` first sampled high at edge E0 → `coin_valid` high after edge E0+DEBOUNCE_CYCLES+4, when the buffer was empty.
- Latency, with the macro undefined: `coin_valid` high after edge E0+4.
- `coin_val` must be stable from E0 until the capture edge. Values changing later do not affect the buffered coin.
- Pop takes effect at the edge where the ack is sampled. The next entry appears after that same edge, so back-to-back acks drain one coin per cycle.
- `pending` and `reject_ind` update on the same edge as the push or pop that affects them.
- The consumer holds `coin_ack` for one `clk` cycle per coin. A level held high drains one coin per cycle.

## Configuration
- `COIN_INTAKE_DEBOUNCE_EN`:
  - Defined: the debounce counter is used as described above.
  - Undefined: the counter is removed, and the debounced level equals synchronized `insert`. Every synchronized rising edge pushes a coin, including bounces.
  - The undefined build is for fast simulation only.

## Test plan
- `DEBOUNCE_CYCLES`=4, macro defined. Clean press with `coin_val`=2'b01 → `coin_valid` high at edge E0+8, `coin_amount`=5, `pending`=1. Ack one cycle → `coin_valid`=0, `pending`=0.
- Bounce: `insert` toggling every 2 cycles for 20 cycles, then steady high → exactly one coin pushed.
- Five presses of code 2'b10 with no ack, `FIFO_DEPTH`=4 → `pending`=4, fifth press sets `reject_ind`=1. Four acks return 10 each, in order.
- Press with code 2'b11 → no push, `reject_ind`=1. Next valid press with 2'b00 → pushes 1 and clears `reject_ind`.
- Buffer full, push and ack on the same edge → `pending` stays 4, new coin is last out.
- Three coins buffered, then `power` low for 1 cycle → `pending`=0, `coin_valid`=0. `rst_n` pulse mid-debounce → no coin pushed, all outputs 0.

Source files
------------

// File: rtl/coin_intake.sv
// coin_intake: coin-slot front end for the vending FSM.
// Synchronizes the raw insert button and denomination switches, debounces the
// button, decodes each accepted press into a coin amount and buffers coins in a
// small FIFO presented through a registered valid/ack head.
// Build option: define COIN_INTAKE_DEBOUNCE_EN to enable the debounce counter.
// Without it the debounced level follows synchronized insert directly, so every
// bounce becomes a coin; that build is intended for fast simulation only.
module coin_intake #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       power,
    input  logic       insert,
    input  logic [1:0] coin_val,
    output logic       coin_valid,
    output logic [3:0] coin_amount,
    input  logic       coin_ack,
    output logic       reject_ind,
    output logic [4:0] pending
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [1:0]    ins_sync;
    logic [1:0]    val_s1;
    logic [1:0]    val_s2;
    logic          ins_s2;
    logic          deb_lvl;
    logic          deb_prev;
    logic          deb_rise;
    logic          press_q;
    logic [1:0]    code_q;
    logic [3:0]    amount;
    logic          code_ok;
    logic [3:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_next;
    logic [4:0]    count;
    logic [4:0]    remain;
    logic          out_valid;
    logic [3:0]    out_amt;
    logic          reject;
    logic          pop;
    logic          full;
    logic          push;
    logic          reject_evt;

    assign ins_s2 = ins_sync[1];

    // Two-flop synchronizers for the button and the denomination switches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ins_sync <= '0;
            val_s1   <= '0;
            val_s2   <= '0;
        end else begin
            ins_sync <= {ins_sync[0], insert};
            val_s1   <= coin_val;
            val_s2   <= val_s1;
        end
    end

`ifdef COIN_INTAKE_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] deb_cnt;

    // Debounce: the level flips only after differing for DEBOUNCE_CYCLES samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            deb_lvl <= 1'b0;
        end else if (!power) begin
            deb_cnt <= '0;
            deb_lvl <= ins_s2;
        end else if (ins_s2 != deb_lvl) begin
            if (deb_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb_lvl <= ins_s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + CW'(1);
            end
        end else begin
            deb_cnt <= '0;
        end
    end
`else
    assign deb_lvl = ins_s2;
`endif

    assign deb_rise = deb_lvl & ~deb_prev;

    // Rising-edge detect on the debounced level; latch the code with the press.
    // While powered down the edge reference tracks the synchronized level, so a
    // press held across power-up is not seen as a new edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_prev <= 1'b0;
            press_q  <= 1'b0;
            code_q   <= '0;
        end else if (!power) begin
            deb_prev <= ins_s2;
            press_q  <= 1'b0;
        end else begin
            deb_prev <= deb_lvl;
            press_q  <= deb_rise;
            if (deb_rise) begin
                code_q <= val_s2;
            end
        end
    end

    // Denomination decode of the captured code
    always_comb begin
        amount  = '0;
        code_ok = 1'b1;
        case (code_q)
            2'b00:   amount = 4'd1;
            2'b01:   amount = 4'd5;
            2'b10:   amount = 4'd10;
            default: code_ok = 1'b0;
        endcase
    end

    // Push/pop qualification; a pop frees the slot for a same-cycle push
    always_comb begin
        pop        = out_valid & coin_ack;
        full       = (count == 5'(FIFO_DEPTH));
        push       = press_q & code_ok & (~full | pop);
        reject_evt = press_q & ~push;
        rd_next    = pop ? rd_ptr + PW'(1) : rd_ptr;
        remain     = count - {4'b0, pop};
    end

    // Coin buffer, occupancy, reject flag and registered head output.
    // The head register is loaded from entries already stored before this edge,
    // so a push into an empty buffer shows up one edge after pending counts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_amt   <= '0;
            reject    <= 1'b0;
        end else if (!power) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_amt   <= '0;
            reject    <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= amount;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_next;
            count  <= count + {4'b0, push} - {4'b0, pop};
            if (push) begin
                reject <= 1'b0;
            end else if (reject_evt) begin
                reject <= 1'b1;
            end
            out_valid <= (remain != 5'd0);
            out_amt   <= (remain != 5'd0) ? mem[rd_next] : 4'd0;
        end
    end

    assign coin_valid  = out_valid;
    assign coin_amount = out_amt;
    assign reject_ind  = reject;
    assign pending     = count;

endmodule

// File: tb/tb_coin_intake.sv
// Self-checking bench for coin_intake: directed steps with randomized coin
// codes and bounce counts, checked against a queue-based model of the buffer.
module tb_coin_intake;

    localparam int unsigned D     = 4;
    localparam int unsigned DEPTH = 4;
`ifdef COIN_INTAKE_DEBOUNCE_EN
    localparam int LAT = D + 4;
    localparam bit DEB = 1'b1;
`else
    localparam int LAT = 4;
    localparam bit DEB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       power;
    logic       insert;
    logic [1:0] coin_val;
    logic       coin_valid;
    logic [3:0] coin_amount;
    logic       coin_ack;
    logic       reject_ind;
    logic [4:0] pending;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    bit exp_rej = 1'b0;

    coin_intake #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .power       (power),
        .insert      (insert),
        .coin_val    (coin_val),
        .coin_valid  (coin_valid),
        .coin_amount (coin_amount),
        .coin_ack    (coin_ack),
        .reject_ind  (reject_ind),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    function automatic int value_of(input int code);
        case (code)
            0:       return 1;
            1:       return 5;
            2:       return 10;
            default: return 0;
        endcase
    endfunction

    task automatic model_push(input int code);
        if (code == 3) exp_rej = 1'b1;
        else if (exp_q.size() == DEPTH) exp_rej = 1'b1;
        else begin
            exp_q.push_back(value_of(code));
            exp_rej = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_model(input string tag);
        check({tag, "_pending"}, 32'(pending), 32'(exp_q.size()));
        check({tag, "_reject"}, 32'(reject_ind), 32'(exp_rej));
        check({tag, "_valid"}, 32'(coin_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) check({tag, "_amount"}, 32'(coin_amount), 32'(exp_q[0]));
        else check({tag, "_amount"}, 32'(coin_amount), 32'd0);
    endtask

    // Press with nb short bounces, hold, release; model the resulting pushes.
    task automatic press(input string tag, input int code, input int nb);
        int pushes;
        coin_val = 2'(code);
        for (int i = 0; i < nb; i++) begin
            insert = 1'b1;
            ticks(2);
            insert = 1'b0;
            ticks(2);
        end
        insert = 1'b1;
        ticks(LAT + 4);
        insert = 1'b0;
        ticks(D + 8);
        pushes = DEB ? 1 : nb + 1;
        for (int i = 0; i < pushes; i++) model_push(code);
        check({tag, "_pending"}, 32'(pending), 32'(exp_q.size()));
        check({tag, "_reject"}, 32'(reject_ind), 32'(exp_rej));
    endtask

    task automatic pop_one(input string tag);
        int n = 0;
        while (!coin_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_wait_valid"}, 32'(coin_valid), 32'd1);
        check({tag, "_amount"}, 32'(coin_amount), 32'(exp_q[0]));
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        void'(exp_q.pop_front());
        check({tag, "_pending"}, 32'(pending), 32'(exp_q.size()));
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) pop_one(tag);
    endtask

    initial begin
        int newc;
        rst_n    = 1'b0;
        power    = 1'b1;
        insert   = 1'b0;
        coin_val = 2'b00;
        coin_ack = 1'b0;
        ticks(3);
        check("rst_valid", 32'(coin_valid), 32'd0);
        check("rst_amount", 32'(coin_amount), 32'd0);
        check("rst_reject", 32'(reject_ind), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        rst_n = 1'b1;
        ticks(2);

        // Latency of a clean press with code 01
        coin_val = 2'b01;
        insert   = 1'b1;
        for (int k = 0; k <= LAT; k++) begin
            tick();
            if (k == LAT - 2) check("lat_pending_before", 32'(pending), 32'd0);
            if (k == LAT - 1) begin
                check("lat_pending_push", 32'(pending), 32'd1);
                check("lat_valid_early", 32'(coin_valid), 32'd0);
            end
            if (k == LAT) begin
                check("lat_valid", 32'(coin_valid), 32'd1);
                check("lat_amount", 32'(coin_amount), 32'd5);
            end
        end
        ticks(4);
        insert = 1'b0;
        ticks(D + 8);
        model_push(1);
        pop_one("first_pop");
        check("first_pop_valid", 32'(coin_valid), 32'd0);
        check("first_pop_amount", 32'(coin_amount), 32'd0);

        // Ack with nothing presented is ignored
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        ticks(2);
        check_model("idle_ack");

        // Bouncy press
        press("bounce", $urandom_range(0, 2), 5);
        check_model("bounce_settled");
        drain("bounce_drain");

        // Overfill with code 10
        for (int i = 0; i < 5; i++) press("fill", 2, 0);
        check("fill_pending", 32'(pending), 32'd4);
        check("fill_reject", 32'(reject_ind), 32'd1);
        drain("fill_drain");

        // Invalid code, then valid code clears the flag
        press("invalid", 3, 0);
        press("valid_after", 0, 0);
        check_model("valid_after_model");
        drain("inv_drain");

        // Full buffer with push and ack on the same edge
        for (int i = 0; i < 4; i++) press("prefill", $urandom_range(0, 2), 0);
        newc     = $urandom_range(0, 2);
        coin_val = 2'(newc);
        insert   = 1'b1;
        for (int k = 0; k <= LAT - 2; k++) tick();
        check("simul_head", 32'(coin_amount), 32'(exp_q[0]));
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        void'(exp_q.pop_front());
        model_push(newc);
        check("simul_pending", 32'(pending), 32'd4);
        check("simul_reject", 32'(reject_ind), 32'd0);
        ticks(4);
        insert = 1'b0;
        ticks(D + 8);
        check_model("simul_settled");
        drain("simul_drain");

        // Randomized mix of presses and pops
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 2) == 0 && exp_q.size() > 0) pop_one("rnd_pop");
            else press("rnd_press", $urandom_range(0, 3), $urandom_range(0, 2));
        end
        check_model("rnd_end");
        drain("rnd_drain");

        // Power drop flushes three buffered coins
        for (int i = 0; i < 3; i++) press("pwr_fill", $urandom_range(0, 2), 0);
        check("pwr_fill_pending", 32'(pending), 32'd3);
        power = 1'b0;
        tick();
        power = 1'b1;
        tick();
        exp_q.delete();
        exp_rej = 1'b0;
        check_model("pwr_flush");

        // Press held across power-up does not register
        power  = 1'b0;
        insert = 1'b1;
        ticks(6);
        power = 1'b1;
        ticks(LAT + 8);
        check("pwr_held_pending", 32'(pending), 32'd0);
        insert = 1'b0;
        ticks(D + 8);
        check_model("pwr_held_release");

        // Reset pulse mid-debounce
        coin_val = 2'b10;
        insert   = 1'b1;
        ticks(DEB ? 3 : 1);
        rst_n  = 1'b0;
        insert = 1'b0;
        #2;
        check("rst_mid_valid", 32'(coin_valid), 32'd0);
        check("rst_mid_amount", 32'(coin_amount), 32'd0);
        check("rst_mid_reject", 32'(reject_ind), 32'd0);
        check("rst_mid_pending", 32'(pending), 32'd0);
        tick();
        rst_n = 1'b1;
        ticks(LAT + 16);
        check_model("rst_mid_after");

        // Still functional after reset
        press("post_rst", 1, 0);
        pop_one("post_rst_pop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
